inst_fetch_queue: RTL and testbench

- Parametrised successor to the fixed 64-bit/2-instruction fetch splitter.
- Accepts an aligned fetch packet of FETCH_N 32-bit instructions plus its fetch PC, discards lanes below the PC's in-packet offset, and enqueues the rest, each tagged with its PC, into a circular buffer of DEPTH entries.
- Presents up to ISSUE_N oldest instructions per cycle to decode, which pops 0..ISSUE_N of them.
- Sits between the instruction SRAM response and the dual-issue decode stage, decoupling fetch from issue stalls.

---
 rtl/cdim_fetch_pkg.sv | 17 +
 rtl/fetch_aligner.sv | 32 +++
 rtl/inst_fetch_queue.sv | 93 +++++++++
 tb/tb_inst_fetch_queue.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cdim_fetch_pkg.sv
// Shared types and helpers for the instruction fetch queue.
// Fetch packets are left-justified to MAX_FETCH lanes, so lane 0 always sits in the top word.
package cdim_fetch_pkg;
    localparam int INST_W    = 32;
    localparam int MAX_FETCH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fq_entry_t;

    // rdata must be left-justified: lane k lives at the k-th word from the MSB end.
    function automatic logic [INST_W-1:0] lane_sel(input logic [MAX_FETCH*INST_W-1:0] rdata,
                                                   input int k);
        return rdata[(MAX_FETCH-k)*INST_W-1 -: INST_W];
    endfunction
endpackage

// File: rtl/fetch_aligner.sv
// Drops the packet lanes below the fetch PC's in-packet offset and compacts
// the remaining lanes, each tagged with its PC, down to index 0.
module fetch_aligner
    import cdim_fetch_pkg::*;
#(
    parameter int FETCH_N = 2
) (
    input  logic [31:0]                    fetch_pc,
    input  logic [FETCH_N*INST_W-1:0]      fetch_rdata,
    output logic [$clog2(FETCH_N):0]       push_n,
    output fq_entry_t [FETCH_N-1:0]        entries
);
    localparam int OFF_W = $clog2(FETCH_N);
    localparam int LJ_W  = MAX_FETCH*INST_W;

    logic [OFF_W-1:0] off;
    logic [LJ_W-1:0]  rdata_lj;

    assign off      = fetch_pc[OFF_W+1:2];
    assign rdata_lj = LJ_W'(fetch_rdata) << ((MAX_FETCH-FETCH_N)*INST_W);
    assign push_n   = (OFF_W+1)'(FETCH_N) - {1'b0, off};

    always_comb begin
        for (int j = 0; j < FETCH_N; j++) begin
            entries[j] = '0;
            if (j < int'(push_n)) begin
                entries[j].inst = lane_sel(rdata_lj, int'(off) + j);
                entries[j].pc   = fetch_pc + 32'(4*j);
            end
        end
    end
endmodule

// File: rtl/inst_fetch_queue.sv
// Circular instruction queue between the I-SRAM response and decode: takes aligned
// fetch packets, presents up to ISSUE_N oldest entries combinationally from the head.
module inst_fetch_queue
    import cdim_fetch_pkg::*;
#(
    parameter int FETCH_N = 2,
    parameter int DEPTH   = 16,
    parameter int ISSUE_N = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        fetch_valid,
    input  logic [31:0]                 fetch_pc,
    input  logic [FETCH_N*INST_W-1:0]   fetch_rdata,
    output logic                        fetch_ready,
    input  logic [$clog2(ISSUE_N):0]    deq_num,
    output logic [ISSUE_N-1:0]          out_valid,
    output logic [ISSUE_N*INST_W-1:0]   out_inst,
    output logic [ISSUE_N*INST_W-1:0]   out_pc,
    output logic [$clog2(DEPTH):0]      count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PN_W  = $clog2(FETCH_N) + 1;

    logic [PTR_W-1:0]      head, tail;
    fq_entry_t             mem [DEPTH];
    logic [PN_W-1:0]       push_n;
    fq_entry_t [FETCH_N-1:0] entries;
    logic                  push;
    logic [CNT_W-1:0]      push_cnt, pop_cnt;

    fetch_aligner #(.FETCH_N(FETCH_N)) u_align (
        .fetch_pc    (fetch_pc),
        .fetch_rdata (fetch_rdata),
        .push_n      (push_n),
        .entries     (entries)
    );

    // Ready looks only at registered occupancy, keeping decode off the fetch timing path.
    assign fetch_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_N);
    assign push        = fetch_valid & fetch_ready & ~flush;
    assign push_cnt    = push ? CNT_W'(push_n) : '0;

    always_comb begin
        int lim;
        lim = ISSUE_N;
        if (int'(deq_num) < lim) lim = int'(deq_num);
        if (int'(count) < lim)   lim = int'(count);
        pop_cnt = CNT_W'(lim);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_cnt);
            tail  <= tail + PTR_W'(push_cnt);
            count <= count + push_cnt - pop_cnt;
        end
    end

    // Storage is not reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int j = 0; j < FETCH_N; j++) begin
                if (j < int'(push_n)) mem[tail + PTR_W'(j)] <= entries[j];
            end
        end
    end

    always_comb begin
        fq_entry_t slot;
        out_valid = '0;
        out_inst  = '0;
        out_pc    = '0;
        for (int i = 0; i < ISSUE_N; i++) begin
            slot = mem[head + PTR_W'(i)];
            if (i < int'(count)) begin
                out_valid[i]                 = 1'b1;
                out_inst[i*INST_W +: INST_W] = slot.inst;
                out_pc[i*INST_W +: INST_W]   = slot.pc;
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized scoreboard bench for inst_fetch_queue: the model is a plain queue of
// (pc, inst) pairs that the stimulus fills and the monitor drains.
module tb_inst_fetch_queue;
    localparam int FETCH_N = 2;
    localparam int DEPTH   = 16;
    localparam int ISSUE_N = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        flush;
    logic                        fetch_valid;
    logic [31:0]                 fetch_pc;
    logic [FETCH_N*32-1:0]       fetch_rdata;
    logic                        fetch_ready;
    logic [$clog2(ISSUE_N):0]    deq_num;
    logic [ISSUE_N-1:0]          out_valid;
    logic [ISSUE_N*32-1:0]       out_inst;
    logic [ISSUE_N*32-1:0]       out_pc;
    logic [$clog2(DEPTH):0]      count;

    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;
    ent_t exp_q[$];

    inst_fetch_queue #(.FETCH_N(FETCH_N), .DEPTH(DEPTH), .ISSUE_N(ISSUE_N)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_rdata (fetch_rdata),
        .fetch_ready (fetch_ready),
        .deq_num     (deq_num),
        .out_valid   (out_valid),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the presented window with the model, then retires what decode took.
    always begin
        int n, popn;
        @(negedge clk);
        #2;
        if (mon_en) begin
            n = exp_q.size();
            chk("count", 32'(count), 32'(n));
            chk("fetch_ready", 32'(fetch_ready), 32'((DEPTH - n) >= FETCH_N));
            for (int i = 0; i < ISSUE_N; i++) begin
                if (i < n) begin
                    chk($sformatf("valid%0d", i), 32'(out_valid[i]), 32'd1);
                    chk($sformatf("inst%0d", i), out_inst[i*32 +: 32], exp_q[i].inst);
                    chk($sformatf("pc%0d", i), out_pc[i*32 +: 32], exp_q[i].pc);
                end else begin
                    chk($sformatf("valid%0d", i), 32'(out_valid[i]), 32'd0);
                    chk($sformatf("inst%0d_zero", i), out_inst[i*32 +: 32], 32'd0);
                    chk($sformatf("pc%0d_zero", i), out_pc[i*32 +: 32], 32'd0);
                end
            end
            popn = int'(deq_num);
            if (n < popn) popn = n;
            if (ISSUE_N < popn) popn = ISSUE_N;
            repeat (popn) void'(exp_q.pop_front());
        end
    end

    // One clock of stimulus; the model absorbs an accepted packet after the edge.
    task automatic drive(input bit fv, input logic [31:0] pc, input logic [FETCH_N*32-1:0] rdata,
                         input int dq, input bit fl);
        bit acc;
        int off;
        ent_t e;
        logic [FETCH_N*32-1:0] tmp;
        @(negedge clk);
        fetch_valid = fv;
        fetch_pc    = pc;
        fetch_rdata = rdata;
        deq_num     = dq[$clog2(ISSUE_N):0];
        flush       = fl;
        acc = fv && !fl && ((DEPTH - exp_q.size()) >= FETCH_N);
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
        end else if (acc) begin
            off = int'((pc >> 2) % FETCH_N);
            for (int k = off; k < FETCH_N; k++) begin
                tmp    = rdata >> ((FETCH_N - 1 - k) * 32);
                e.inst = tmp[31:0];
                e.pc   = pc + 32'(4 * (k - off));
                exp_q.push_back(e);
            end
        end
    endtask

    function automatic logic [FETCH_N*32-1:0] rand_pkt();
        logic [FETCH_N*32-1:0] r;
        for (int k = 0; k < FETCH_N; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_pc = '0; fetch_rdata = '0; deq_num = '0;
        #3;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(fetch_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_inst", out_inst[31:0], 32'd0);
        chk("rst_pc", out_pc[31:0], 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Aligned fill to full, then one more packet that must be held back.
        for (int c = 0; c < 9; c++) drive(1, 32'h1000, {32'hAAAA_0000, 32'hBBBB_0000}, 0, 0);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_ready", 32'(fetch_ready), 32'd0);
        for (int c = 0; c < 8; c++) drive(0, 32'h0, '0, 2, 0);

        // Misaligned packet keeps only the second lane; then over-pop from count 1.
        drive(1, 32'h1004, {32'h1111_1111, 32'h2222_2222}, 0, 0);
        chk("misal_count", 32'(count), 32'd1);
        chk("misal_inst", out_inst[31:0], 32'h2222_2222);
        drive(0, 32'h0, '0, 2, 0);
        chk("overpop_count", 32'(count), 32'd0);

        // Reach 3, then push 2 and pop 2 together.
        drive(1, 32'h2000, {32'hC000_0000, 32'hC000_0001}, 0, 0);
        drive(1, 32'h2004, {32'hC000_0002, 32'hC000_0003}, 0, 0);
        drive(1, 32'h2008, {32'hC000_0004, 32'hC000_0005}, 2, 0);
        chk("simul_count", 32'(count), 32'd3);
        chk("simul_head", out_inst[31:0], 32'hC000_0003);

        // Steady push-2/pop-2 so both windows cross the wrap point.
        for (int c = 0; c < 8; c++) drive(1, 32'h3000 + 32'(8*c), rand_pkt(), 2, 0);

        // Reach 7 and flush with a simultaneous push and pop.
        drive(1, 32'h4000, rand_pkt(), 0, 0);
        drive(1, 32'h4008, rand_pkt(), 0, 0);
        chk("pre_flush_count", 32'(count), 32'd7);
        drive(1, 32'h4010, rand_pkt(), 2, 1);
        chk("flush_count", 32'(count), 32'd0);

        // Fill to 5, then reset between clock edges.
        drive(1, 32'h5000, rand_pkt(), 0, 0);
        drive(1, 32'h5008, rand_pkt(), 0, 0);
        drive(1, 32'h5014, rand_pkt(), 0, 0);
        chk("pre_rst_count", 32'(count), 32'd5);
        #2;
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ready", 32'(fetch_ready), 32'd1);
        chk("arst_inst", out_inst[31:0], 32'd0);
        exp_q.delete();
        rst    = 1'b0;
        mon_en = 1'b1;

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, rand_pkt(),
                  int'($urandom_range(0, 3)), $urandom_range(0, 40) == 0);
        end
        drive(0, 32'h0, '0, 0, 0);
        @(negedge clk);
        #3;
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
